// File: rtl/io_pkg.sv
// Shared I/O definitions: port address, data width, debounce states, status flags.
// Used by the parallel input port, the load mux and the output-port store decode.
package io_pkg;

  localparam int         IO_WIDTH     = 8;
  localparam logic [7:0] IO_PORT_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE,
    S_HIGH,
    S_FALL
  } deb_state_e;

  typedef struct packed {
    logic ready;
    logic ovr;
  } port_status_t;

  function automatic logic port_hit(input logic rd, input logic [7:0] addr,
                                    input logic [7:0] port);
    return rd && (addr == port);
  endfunction

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer with asynchronous active-high reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/parallel_input_port.sv
// Parallel input port: synchronizes pin bus and strobe, latches data on a clean strobe rise.
// Build option PIN_DEBOUNCE_EN selects the debounce FSM; otherwise a plain edge detector.
module parallel_input_port
  import io_pkg::*;
#(
  parameter int         WIDTH           = IO_WIDTH,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [7:0] PORT_ADDR       = IO_PORT_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_data,
  input  logic             pin_strobe,
  input  logic [7:0]       Address,
  input  logic             MemRead,
  output logic [WIDTH-1:0] DataIn,
  output logic             data_ready,
  output logic             overrun
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
    $error("parallel_input_port: DEBOUNCE_CYCLES out of range 1..255");
  end

  logic             strobe_s;
  logic [WIDTH-1:0] data_s;
  logic             capture;
  logic             port_rd;
  port_status_t     st;

  sync2 #(.W(1)) u_sync_strobe (
    .clk (clk),
    .rst (rst),
    .d   (pin_strobe),
    .q   (strobe_s)
  );

  sync2 #(.W(WIDTH)) u_sync_data (
    .clk (clk),
    .rst (rst),
    .d   (pin_data),
    .q   (data_s)
  );

  assign port_rd = port_hit(MemRead, Address, PORT_ADDR);

`ifdef PIN_DEBOUNCE_EN
  localparam logic [7:0] DEB_N = 8'(DEBOUNCE_CYCLES);

  deb_state_e state;
  logic [7:0] cnt;

  // Capture fires on the edge that accepts the rising level.
  assign capture = (state == S_RISE) && strobe_s && (cnt == DEB_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= '0;
    end else begin
      case (state)
        S_LOW: begin
          if (strobe_s) begin
            state <= S_RISE;
            cnt   <= 8'd1;
          end
        end
        S_RISE: begin
          if (!strobe_s)          state <= S_LOW;
          else if (cnt == DEB_N)  state <= S_HIGH;
          else                    cnt   <= cnt + 8'd1;
        end
        S_HIGH: begin
          if (!strobe_s) begin
            state <= S_FALL;
            cnt   <= 8'd1;
          end
        end
        S_FALL: begin
          if (strobe_s)           state <= S_HIGH;
          else if (cnt == DEB_N)  state <= S_LOW;
          else                    cnt   <= cnt + 8'd1;
        end
        default: state <= S_LOW;
      endcase
    end
  end
`else
  logic strobe_q;

  assign capture = strobe_s && !strobe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) strobe_q <= 1'b0;
    else     strobe_q <= strobe_s;
  end
`endif

  // A read in the same cycle as a capture consumes the old data, so overrun clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DataIn <= '0;
      st     <= '0;
    end else if (capture) begin
      DataIn   <= data_s;
      st.ready <= 1'b1;
      st.ovr   <= port_rd ? 1'b0 : (st.ovr | st.ready);
    end else if (port_rd) begin
      st <= '0;
    end
  end

  assign data_ready = st.ready;
  assign overrun    = st.ovr;

endmodule

// File: tb/tb_parallel_input_port.sv
// Directed bench for parallel_input_port: run-length strobe model checked every cycle plus literals.
module tb_parallel_input_port;

  localparam int D = 4;
`ifdef PIN_DEBOUNCE_EN
  localparam int LAT = 3 + D;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pin_data;
  logic       pin_strobe;
  logic [7:0] Address;
  logic       MemRead;
  logic [7:0] DataIn;
  logic       data_ready;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  // model state
  logic [7:0] m_data;
  logic       m_rdy, m_ovr;
  logic       ps_h0, ps_h1;
  logic [7:0] pd_h0, pd_h1;
  logic       m_level, m_prev;
  int         m_run;

  parallel_input_port #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .PORT_ADDR(8'hFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .pin_data   (pin_data),
    .pin_strobe (pin_strobe),
    .Address    (Address),
    .MemRead    (MemRead),
    .DataIn     (DataIn),
    .data_ready (data_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_rdy = 1'b0; m_ovr = 1'b0;
    ps_h0 = 1'b0; ps_h1 = 1'b0; pd_h0 = '0; pd_h1 = '0;
    m_level = 1'b0; m_prev = 1'b0; m_run = 0;
  endtask

  // One clock edge of the model: strobe/data seen by the port are the pin values two edges old.
  task automatic model_edge();
    logic s, cap, rd;
    logic [7:0] d;
    s   = ps_h1;
    d   = pd_h1;
    cap = 1'b0;
`ifdef PIN_DEBOUNCE_EN
    if (s != m_level) m_run++;
    else              m_run = 0;
    if (m_run == D + 1) begin
      m_level = s;
      m_run   = 0;
      cap     = s;
    end
`else
    cap    = s && !m_prev;
    m_prev = s;
`endif
    rd = MemRead && (Address == 8'hFF);
    if (cap) begin
      if (rd)                 m_ovr = 1'b0;
      else if (m_rdy)         m_ovr = 1'b1;
      m_data = d;
      m_rdy  = 1'b1;
    end else if (rd) begin
      m_rdy = 1'b0;
      m_ovr = 1'b0;
    end
    ps_h1 = ps_h0; ps_h0 = pin_strobe;
    pd_h1 = pd_h0; pd_h0 = pin_data;
  endtask

  task automatic cmp_outputs();
    chk("DataIn", DataIn, m_data);
    chk("data_ready", {7'd0, data_ready}, {7'd0, m_rdy});
    chk("overrun", {7'd0, overrun}, {7'd0, m_ovr});
  endtask

  // Called at a negedge; returns at the next negedge after checking outputs.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    cmp_outputs();
    @(negedge clk);
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic port_read(input logic [7:0] a);
    MemRead = 1'b1; Address = a;
    cyc();
    MemRead = 1'b0; Address = 8'h00;
  endtask

  task automatic capture(input logic [7:0] v);
    pin_data = v;
    cycn(2);
    pin_strobe = 1'b1;
    cycn(10);
    pin_strobe = 1'b0;
    cycn(12);
  endtask

  initial begin
    rst = 1'b1; pin_data = '0; pin_strobe = 1'b0; Address = '0; MemRead = 1'b0;
    model_reset();
    cycn(3);
    rst = 1'b0;

    // reset then idle
    cycn(20);
    chk("idle_data", DataIn, 8'h00);
    chk("idle_rdy", {7'd0, data_ready}, 8'h00);
    chk("idle_ovr", {7'd0, overrun}, 8'h00);

    // basic capture at exact edge
    pin_data = 8'hA5;
    cycn(2);
    pin_strobe = 1'b1;
    cycn(LAT - 1);
    chk("basic_rdy_early", {7'd0, data_ready}, 8'h00);
    cyc();
    chk("basic_data", DataIn, 8'hA5);
    chk("basic_rdy", {7'd0, data_ready}, 8'h01);
    cycn(10 - LAT);
    pin_strobe = 1'b0;
    cycn(12);
    port_read(8'hFF);
    chk("read_rdy", {7'd0, data_ready}, 8'h00);
    chk("read_data", DataIn, 8'hA5);

    // glitch of three cycles
    pin_data = 8'h5A;
    cycn(2);
    pin_strobe = 1'b1;
    cycn(3);
    pin_strobe = 1'b0;
    cycn(12);
`ifdef PIN_DEBOUNCE_EN
    chk("glitch_rdy", {7'd0, data_ready}, 8'h00);
    chk("glitch_data", DataIn, 8'hA5);
`endif
    port_read(8'hFF);

    // overrun
    capture(8'h11);
    capture(8'h22);
    chk("ovr_data", DataIn, 8'h22);
    chk("ovr_rdy", {7'd0, data_ready}, 8'h01);
    chk("ovr_flag", {7'd0, overrun}, 8'h01);
    port_read(8'hFF);
    chk("ovr_clr_rdy", {7'd0, data_ready}, 8'h00);
    chk("ovr_clr_flag", {7'd0, overrun}, 8'h00);

    // capture coinciding with a port read
    capture(8'h44);
    capture(8'h55);
    pin_data = 8'h33;
    cycn(2);
    pin_strobe = 1'b1;
    cycn(LAT - 1);
    port_read(8'hFF);
    chk("sim_data", DataIn, 8'h33);
    chk("sim_rdy", {7'd0, data_ready}, 8'h01);
    chk("sim_ovr", {7'd0, overrun}, 8'h00);
    cycn(10 - LAT);
    pin_strobe = 1'b0;
    cycn(12);
    port_read(8'hFE);
    chk("fe_rdy", {7'd0, data_ready}, 8'h01);
    chk("fe_data", DataIn, 8'h33);
    port_read(8'hFF);

    // reset in the middle of debounce, strobe kept high
    pin_data = 8'h77;
    cycn(2);
    pin_strobe = 1'b1;
    cycn(4);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_data", DataIn, 8'h00);
    chk("rst_rdy", {7'd0, data_ready}, 8'h00);
    chk("rst_ovr", {7'd0, overrun}, 8'h00);
    @(negedge clk);
    cycn(2);
    rst = 1'b0;
    cycn(LAT - 1);
    chk("rst_rdy_early", {7'd0, data_ready}, 8'h00);
    cyc();
    chk("rst_cap_data", DataIn, 8'h77);
    chk("rst_cap_rdy", {7'd0, data_ready}, 8'h01);
    pin_strobe = 1'b0;
    cycn(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
